axis_uart_bridge_tx: RTL and testbench

AXIS_UART_BRIDGE_TX -- requirements
Module: axis_uart_bridge_tx

---
 rtl/axis_uart_bridge_tx.sv | 165 ++++++++++++++++
 tb/tb_axis_uart_bridge_tx.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_uart_bridge_tx.sv
// AXI-Stream word to UART serializer: sends N_BYTES bytes per word, byte 0 first, LSB first, 8N1.
// Define AXIS_UART_BRIDGE_TX_PARITY_EN to insert an even-parity bit before each stop bit (8E1).
module axis_uart_bridge_tx #(
    parameter int UART_SPEED = 115200,
    parameter int FREQ_HZ    = 100000000,
    parameter int N_BYTES    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BYTES*8-1:0] S_AXIS_TDATA,
    input  logic                 S_AXIS_TVALID,
    output logic                 S_AXIS_TREADY,
    output logic                 UART_TX,
    output logic                 BUSY
);

    localparam int CLOCK_DURATION = FREQ_HZ / UART_SPEED;
    localparam int CNT_W  = (CLOCK_DURATION > 2) ? $clog2(CLOCK_DURATION) : 1;
    localparam int BYTE_W = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    generate
        if (CLOCK_DURATION < 2 || N_BYTES < 1) begin : g_bad_cfg
            $error("axis_uart_bridge_tx: need FREQ_HZ/UART_SPEED >= 2 and N_BYTES >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [N_BYTES*8-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
    logic                 parity_q, parity_d;
`endif
    logic                 bit_end;

    assign bit_end = (bit_cnt_q == CNT_W'(CLOCK_DURATION - 1));

    // tx_d carries the level of the bit the FSM is entering, so the line is registered.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q == IDLE) begin
            bit_cnt_d = '0;
        end else begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (S_AXIS_TVALID && ready_q) begin
                    shift_d    = S_AXIS_TDATA;
                    byte_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
                    parity_d  = ^shift_q[7:0];
`endif
                end
            end
            DATA: begin
                if (bit_end) begin
                    // Shifting after every bit leaves the next byte in shift_q[7:0].
                    shift_d   = shift_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (byte_cnt_q == BYTE_W'(N_BYTES - 1)) begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        state_d    = START;
                        byte_cnt_d = byte_cnt_q + BYTE_W'(1);
                        tx_d       = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b0;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign S_AXIS_TREADY = ready_q & ~reset;
    assign UART_TX       = tx_q;
    assign BUSY          = (state_q != IDLE);

endmodule

// File: tb/tb_axis_uart_bridge_tx.sv
// Randomized scoreboard bench for axis_uart_bridge_tx: a behavioural UART receiver checks the line,
// while a cycle-window model checks acceptance time, BUSY and S_AXIS_TREADY.
module tb_axis_uart_bridge_tx;

    localparam int N_BYTES = 2;
    localparam int FREQ    = 1000000;
    localparam int SPEED   = 100000;
    localparam int CD      = FREQ / SPEED;
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
    localparam int F = 11;
`else
    localparam int F = 10;
`endif
    localparam int WORD_CYC = N_BYTES * F * CD;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [N_BYTES*8-1:0] tdata = '0;
    logic                 tvalid = 1'b0;
    logic                 tready;
    logic                 uart_tx;
    logic                 busy;

    axis_uart_bridge_tx #(
        .UART_SPEED(SPEED),
        .FREQ_HZ   (FREQ),
        .N_BYTES   (N_BYTES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .S_AXIS_TDATA (tdata),
        .S_AXIS_TVALID(tvalid),
        .S_AXIS_TREADY(tready),
        .UART_TX      (uart_tx),
        .BUSY         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         start;
    } frame_t;

    frame_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  hs_count = 0;
    int  earliest = 0;
    int  pend_since = 0;
    bit  pend = 1'b0;
    bit  rst_at_edge = 1'b1;
    int  busy_lo = 1;
    int  busy_hi = 0;

    function automatic void check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Acceptance model: a word is taken at the later of "TVALID first seen" and "block free".
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                exp_q.delete();
                busy_lo     = 0;
                busy_hi     = -1;
                earliest    = cyc + 2;
                rst_at_edge = 1'b1;
            end else begin
                rst_at_edge = 1'b0;
                if (tvalid && !pend) begin
                    pend       = 1'b1;
                    pend_since = cyc;
                end
                if (tvalid && tready) begin
                    check("accept_cycle", cyc, (pend_since > earliest) ? pend_since : earliest);
                    pend = 1'b0;
                    hs_count++;
                    $display("accept word 0x%h at cycle %0d", tdata, cyc);
                    for (int b = 0; b < N_BYTES; b++) begin
                        frame_t fr;
                        fr.data  = tdata[8*b +: 8];
                        fr.start = cyc + 1 + b * F * CD;
                        exp_q.push_back(fr);
                    end
                    busy_lo  = cyc + 1;
                    busy_hi  = cyc + WORD_CYC;
                    earliest = cyc + 1 + WORD_CYC;
                end
            end
            cyc++;
        end
    end

    // Monitor: samples on the falling edge, decodes frames and pops the scoreboard.
    bit         rx_active = 1'b0;
    int         rx_start = 0;
    logic       rx_cur = 1'b1;
    bit         rx_glitch = 1'b0;
    logic [F-1:0] rx_bits = '0;

    initial begin
        forever begin
            @(negedge clk);
            begin
                bit busy_exp;
                bit ready_exp;
                busy_exp  = (cyc >= busy_lo) && (cyc <= busy_hi);
                ready_exp = !reset && !rst_at_edge && !busy_exp;
                check("busy", busy, busy_exp);
                check("tready", tready, ready_exp);
            end
            if (rst_at_edge) begin
                check("tx_after_reset", uart_tx, 1);
                rx_active = 1'b0;
            end else begin
                if (!rx_active && uart_tx == 1'b0) begin
                    rx_active = 1'b1;
                    rx_start  = cyc;
                    rx_glitch = 1'b0;
                end
                if (rx_active) begin
                    int off;
                    int bitn;
                    int pos;
                    off  = cyc - rx_start;
                    bitn = off / CD;
                    pos  = off % CD;
                    if (pos == 0) rx_cur = uart_tx;
                    else if (uart_tx != rx_cur) rx_glitch = 1'b1;
                    if (pos == CD - 1) begin
                        rx_bits[bitn] = rx_cur;
                        if (bitn == F - 1) begin
                            rx_active = 1'b0;
                            if (exp_q.size() == 0) begin
                                check("unexpected_frame", 1, 0);
                            end else begin
                                frame_t e;
                                e = exp_q.pop_front();
                                $display("frame 0x%h start %0d (expected 0x%h start %0d)",
                                         rx_bits[8:1], rx_start, e.data, e.start);
                                check("frame_start", rx_start, e.start);
                                check("frame_data", rx_bits[8:1], e.data);
`ifdef AXIS_UART_BRIDGE_TX_PARITY_EN
                                check("frame_parity", rx_bits[9], ^e.data);
`endif
                                check("frame_stop", rx_bits[F-1], 1);
                                check("bit_stable", rx_glitch, 0);
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [N_BYTES*8-1:0] w);
        int start_hs;
        start_hs = hs_count;
        tvalid   = 1'b1;
        tdata    = w;
        for (int i = 0; i < 3 * WORD_CYC && hs_count == start_hs; i++) step();
        check("send_accepted", hs_count - start_hs, 1);
        tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2 * WORD_CYC && (busy || exp_q.size() != 0); i++) step();
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        int target;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        send(16'h1234); wait_idle();
        send(16'h00A5); wait_idle();
        send(16'h0001); wait_idle();
        send(16'hFF00); wait_idle();

        // TVALID held high with TDATA churning every cycle: only latched words may appear.
        target = hs_count + 4;
        tvalid = 1'b1;
        for (int i = 0; i < 6 * WORD_CYC && hs_count < target; i++) begin
            tdata = 16'($urandom);
            step();
        end
        tvalid = 1'b0;
        check("burst_accepted", hs_count, target);
        wait_idle();

        for (int k = 0; k < 8; k++) begin
            repeat ($urandom_range(0, 40)) step();
            send(16'($urandom));
        end
        wait_idle();

        // Reset pulse during bit 4 of the first frame; the word must be dropped.
        send(16'($urandom));
        repeat (4 * CD + 3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        send(16'h5AC3);
        wait_idle();
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
